kim_if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core. Owns the program counter, issues fetch requests to instruction memory over a req/ready handshake, and presents one instruction plus its PC+4 per cycle to the IF/ID pipeline register. Handles hazard stalls by buffering a completed fetch, and branch/jump redirects by issuing a flush and discarding any in-flight fetch.

---
 rtl/kim_if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_kim_if_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/kim_if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// buffers a completed fetch across hazard stalls and drops in-flight fetches
// on branch/jump redirect.
// Optional build macro: KIM_IF_ALIGN_CHK_EN (redirect alignment check, misalign_err port).
module kim_if_fetch_stage #(
  parameter int unsigned               PC_ADDR_WIDTH   = 32,
  parameter int unsigned               INST_DATA_WIDTH = 32,
  parameter logic [PC_ADDR_WIDTH-1:0]  RESET_PC        = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         is_mem_hazard,
  input  logic                         is_branch,
  input  logic [PC_ADDR_WIDTH-1:0]     branch_target,
  input  logic                         is_jump,
  input  logic [PC_ADDR_WIDTH-1:0]     jump_target,
  output logic                         imem_req,
  output logic [PC_ADDR_WIDTH-1:0]     imem_addr,
  input  logic                         imem_ready,
  input  logic [INST_DATA_WIDTH-1:0]   imem_rdata,
  output logic [INST_DATA_WIDTH-1:0]   instruction,
  output logic [PC_ADDR_WIDTH-1:0]     pc_next_out,
  output logic                         is_flush,
  output logic                         fetch_busy,
`ifdef KIM_IF_ALIGN_CHK_EN
  output logic                         misalign_err,
`endif
  output logic                         dbg_state
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DROP  = 1'b1
  } state_t;

  state_t                       r_state;
  logic [PC_ADDR_WIDTH-1:0]     r_pc;
  logic [PC_ADDR_WIDTH-1:0]     r_drop_addr;
  logic                         r_buf_valid;
  logic [INST_DATA_WIDTH-1:0]   r_buf_inst;
  logic [PC_ADDR_WIDTH-1:0]     r_buf_pc;

  logic                         w_redirect;
  logic [PC_ADDR_WIDTH-1:0]     w_target_raw;
  logic [PC_ADDR_WIDTH-1:0]     w_target;
  logic                         w_in_drop;
  logic                         w_req;
  logic [PC_ADDR_WIDTH-1:0]     w_pc_plus4;
  logic [PC_ADDR_WIDTH-1:0]     w_buf_pc_plus4;

  // Memory handshake: imem_req is a level held with a stable imem_addr until
  // the cycle imem_ready is high; req && ready in one cycle completes the fetch.
  assign w_redirect     = is_branch | is_jump;
  assign w_target_raw   = is_branch ? branch_target : jump_target;
  assign w_in_drop      = (r_state == S_DROP);
  assign w_req          = rstn & (w_in_drop | ~r_buf_valid);
  assign w_pc_plus4     = r_pc + PC_ADDR_WIDTH'(4);
  assign w_buf_pc_plus4 = r_buf_pc + PC_ADDR_WIDTH'(4);

`ifdef KIM_IF_ALIGN_CHK_EN
  logic r_misalign_err;
  logic w_misalign;
  assign w_misalign   = |w_target_raw[1:0];
  assign w_target     = {w_target_raw[PC_ADDR_WIDTH-1:2], 2'b00};
  assign misalign_err = r_misalign_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_misalign_err <= 1'b0;
    end else if (w_redirect && w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end
`else
  assign w_target = w_target_raw;
`endif

  assign imem_req   = w_req;
  assign imem_addr  = w_in_drop ? r_drop_addr : r_pc;
  assign is_flush   = rstn & w_redirect;
  assign fetch_busy = w_req & ~imem_ready;
  assign dbg_state  = r_state;

  // A redirect or a pending drop turns the slot into a NOP; otherwise the
  // buffered instruction has priority over a live memory completion.
  always_comb begin
    instruction = '0;
    pc_next_out = w_pc_plus4;
    if (rstn && !w_redirect && !w_in_drop) begin
      if (r_buf_valid) begin
        instruction = r_buf_inst;
        pc_next_out = w_buf_pc_plus4;
      end else if (imem_ready && !is_mem_hazard) begin
        instruction = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= '0;
      r_buf_pc    <= '0;
    end else if (w_redirect) begin
      r_pc        <= w_target;
      r_buf_valid <= 1'b0;
      if (w_in_drop) begin
        if (imem_ready) r_state <= S_FETCH;
      end else if (w_req && !imem_ready) begin
        // The outstanding request must keep its address until accepted.
        r_state     <= S_DROP;
        r_drop_addr <= r_pc;
      end
    end else if (w_in_drop) begin
      if (imem_ready) r_state <= S_FETCH;
    end else if (r_buf_valid) begin
      if (!is_mem_hazard) r_buf_valid <= 1'b0;
    end else if (imem_ready) begin
      r_pc <= w_pc_plus4;
      if (is_mem_hazard) begin
        r_buf_valid <= 1'b1;
        r_buf_inst  <= imem_rdata;
        r_buf_pc    <= r_pc;
      end
    end
  end

endmodule

// File: tb/tb_kim_if_fetch_stage.sv
// Directed bench for kim_if_fetch_stage: per-cycle expectations queued by the
// driver, popped and compared by an independent monitor on the falling edge.
module tb_kim_if_fetch_stage;

  logic        clk;
  logic        rstn;
  logic        is_mem_hazard;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        is_jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_next_out;
  logic        is_flush;
  logic        fetch_busy;
  logic        dbg_state;
`ifdef KIM_IF_ALIGN_CHK_EN
  logic        misalign_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        pcn_chk;
    logic [31:0] pcn;
    logic        flush;
    logic        busy;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  kim_if_fetch_stage #(
    .PC_ADDR_WIDTH   (32),
    .INST_DATA_WIDTH (32),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .is_mem_hazard (is_mem_hazard),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .is_jump       (is_jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_next_out   (pc_next_out),
    .is_flush      (is_flush),
    .fetch_busy    (fetch_busy),
`ifdef KIM_IF_ALIGN_CHK_EN
    .misalign_err  (misalign_err),
`endif
    .dbg_state     (dbg_state)
  );

  // Memory content: each word holds its own address plus 0x1000_0000, so
  // a fetched instruction is never confused with a NOP.
  assign imem_rdata = imem_addr + 32'h1000_0000;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, n, act, exp);
    end
  endtask

  // monitor / scoreboard
  int mon_n = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      mon_n++;
      chk("imem_req", mon_n, {31'd0, imem_req}, {31'd0, e.req});
      if (e.req) chk("imem_addr", mon_n, imem_addr, e.addr);
      chk("instruction", mon_n, instruction, e.inst);
      if (e.pcn_chk) chk("pc_next_out", mon_n, pc_next_out, e.pcn);
      chk("is_flush", mon_n, {31'd0, is_flush}, {31'd0, e.flush});
      chk("fetch_busy", mon_n, {31'd0, fetch_busy}, {31'd0, e.busy});
`ifdef KIM_IF_ALIGN_CHK_EN
      chk("misalign_err", mon_n, {31'd0, misalign_err}, {31'd0, e.mis});
`endif
    end
  end

  // driver: apply one cycle of inputs, queue its expected outputs
  task automatic step(input logic rst_n, input logic hz,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic rdy,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_inst,
                      input logic pchk, input logic [31:0] e_pcn,
                      input logic e_flush, input logic e_mis);
    exp_t e;
    rstn          = rst_n;
    is_mem_hazard = hz;
    is_branch     = br;
    branch_target = bt;
    is_jump       = jp;
    jump_target   = jt;
    imem_ready    = rdy;
    e.req     = e_req;
    e.addr    = e_addr;
    e.inst    = e_inst;
    e.pcn_chk = pchk;
    e.pcn     = e_pcn;
    e.flush   = e_flush;
    e.busy    = e_req & ~rdy;
    e.mis     = e_mis;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; is_mem_hazard = 1'b0; is_branch = 1'b0; branch_target = '0;
    is_jump = 1'b0; jump_target = '0; imem_ready = 1'b1;

    // reset: outputs quiet, late imem_ready ignored
    //    rst hz br bt            jp jt            rdy req addr          inst           pchk pcn            fl mis
    step(0, 0, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        32'h0,         1, 32'h4,         0, 0);
    // is_jump during reset still must not flush
    step(0, 0, 0, 32'h0,        1, 32'h500,      1,  0,  32'h0,        32'h0,         1, 32'h4,         0, 0);
    // zero-wait streaming 0x0, 0x4
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h0,        32'h1000_0000, 1, 32'h4,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h4,        32'h1000_0004, 1, 32'h8,         0, 0);
    // hazard for two cycles while 0x8 completes: buffered, then presented
    step(1, 1, 0, 32'h0,        0, 32'h0,        1,  1,  32'h8,        32'h0,         0, 32'h0,         0, 0);
    step(1, 1, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        32'h1000_0008, 1, 32'hC,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        32'h1000_0008, 1, 32'hC,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'hC,        32'h1000_000C, 1, 32'h10,        0, 0);
    // 0x10 stalls 3 cycles, jump to 0x40 in the first: address held, data dropped
    step(1, 0, 0, 32'h0,        1, 32'h40,       0,  1,  32'h10,       32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        0,  1,  32'h10,       32'h0,         0, 32'h0,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        0,  1,  32'h10,       32'h0,         0, 32'h0,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h10,       32'h0,         0, 32'h0,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h40,       32'h1000_0040, 1, 32'h44,        0, 0);
    // branch and jump together: branch wins
    step(1, 0, 1, 32'h100,      1, 32'h200,      1,  1,  32'h44,       32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h100,      32'h1000_0100, 1, 32'h104,       0, 0);
    // PC wrap at the top of the address space
    step(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 1,  32'h104,      32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'hFFFF_FFFC, 32'h0FFF_FFFC, 1, 32'h0,        0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h0,        32'h1000_0000, 1, 32'h4,         0, 0);
    // second redirect while dropping only retargets the PC
    step(1, 0, 0, 32'h0,        1, 32'h80,       0,  1,  32'h4,        32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 1, 32'h200,      0, 32'h0,        0,  1,  32'h4,        32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h4,        32'h0,         0, 32'h0,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h200,      32'h1000_0200, 1, 32'h204,       0, 0);
    // reset while dropping: restart at RESET_PC
    step(1, 0, 0, 32'h0,        1, 32'h300,      0,  1,  32'h204,      32'h0,         0, 32'h0,         1, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        32'h0,         1, 32'h4,         0, 0);
    step(0, 0, 0, 32'h0,        0, 32'h0,        1,  0,  32'h0,        32'h0,         1, 32'h4,         0, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h0,        32'h1000_0000, 1, 32'h4,         0, 0);
`ifdef KIM_IF_ALIGN_CHK_EN
    // misaligned branch target: sticky error, fetch from aligned address
    step(1, 0, 1, 32'h103,      0, 32'h0,        1,  1,  32'h4,        32'h0,         0, 32'h0,         1, 0);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h100,      32'h1000_0100, 1, 32'h104,       0, 1);
    step(1, 0, 0, 32'h0,        0, 32'h0,        1,  1,  32'h104,      32'h1000_0104, 1, 32'h108,       0, 1);
`endif

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
